// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM
// states, wait-counter width and the funct3 legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Stores only support the signed size codes; loads add the unsigned forms.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for little-endian sub-word accesses.
// Store side: byte enables and replicated write data.
// Load side: extraction and sign/zero extension of the addressed lane.
// Low address bits below natural alignment are ignored, which gives the
// masking behaviour when misalignment checking is not built in.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rword[8*addr_lo +: 8];
  assign half_v = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Steer write data into lanes and extend the addressed read lane.
  always_comb begin
    byte_en   = 4'b0000;
    wdata_sh  = '0;
    rdata_ext = '0;
    case (funct3)
      F3_B, F3_BU: begin
        byte_en  = 4'b0001 << addr_lo;
        wdata_sh = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
      end
      F3_W: begin
        byte_en  = 4'b1111;
        wdata_sh = wdata;
      end
      default: begin
        byte_en  = 4'b0000;
        wdata_sh = '0;
      end
    endcase
    case (funct3)
      F3_B:    rdata_ext = {{24{byte_v[7]}}, byte_v};
      F3_BU:   rdata_ext = {24'd0, byte_v};
      F3_H:    rdata_ext = {{16{half_v[15]}}, half_v};
      F3_HU:   rdata_ext = {16'd0, half_v};
      F3_W:    rdata_ext = rword;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed wait
// states, byte-enable BRAM-style array, extended load data on response.
// Optional build macro DMEM_MISALIGN_CHECK_EN turns misaligned halfword and
// word accesses into faults; without it the low address bits are masked.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               write_q, write_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         f3_q, f3_d;

  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               acc_go;
  logic               acc_write;
  logic [31:0]        acc_addr;
  logic [31:0]        acc_wdata;
  logic [2:0]         acc_f3;
  logic [IDX_W-1:0]   word_idx;
  logic               oob;
  logic               misalign;
  logic               acc_err;
  logic               mem_we;
  logic [3:0]         byte_en;
  logic [31:0]        wdata_sh;
  logic [31:0]        rdata_ext;
  logic [31:0]        rword;

  // With zero wait states the access runs on the accept edge straight from
  // the request inputs; otherwise it runs from the latched request.
  assign acc_write = (state_q == IDLE) ? req_write  : write_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr   : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
  assign acc_f3    = (state_q == IDLE) ? req_funct3 : f3_q;

  assign word_idx = acc_addr[IDX_W+1:2];
  assign oob      = |(acc_addr >> (IDX_W + 2));

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = (((acc_f3 == F3_H) || (acc_f3 == F3_HU)) && acc_addr[0]) ||
                    ((acc_f3 == F3_W) && (acc_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign acc_err = oob || misalign || !f3_legal(acc_write, acc_f3);
  assign mem_we  = acc_go && acc_write && !acc_err && rst;
  assign rword   = mem_q[word_idx];

  dmem_lane_align u_align (
    .funct3    (acc_f3),
    .addr_lo   (acc_addr[1:0]),
    .wdata     (acc_wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  assign req_ready = (state_q == IDLE) && rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Next-state, wait counter, request latch and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    acc_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          if (WAIT_CYCLES == 0) begin
            acc_go  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          acc_go  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (acc_go) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_write) ? '0 : rdata_ext;
    end
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request latch; contents are only meaningful outside IDLE.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    f3_q    <= f3_d;
  end

  // Byte-enable memory write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule
